// File: rtl/eth_rx_pkg.sv
// Shared definitions for the RGMII receive path: speed codes, preamble/SFD
// values, CRC-32 constants and the framer state type.
package eth_rx_pkg;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    // Nibble forms seen on the wire in 10/100 mode (low nibble first).
    localparam logic [3:0] PREAMBLE_NIB  = 4'h5;
    localparam logic [3:0] SFD_NIB       = 4'hD;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // The datapath shifts LSB-first, so it works with the mirrored polynomial.
    localparam logic [31:0] CRC32_POLY_REFL = bitrev32(CRC32_POLY);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

endpackage

// File: rtl/rgmii_rx_frame_if.sv
// Received byte stream towards the packet path.
interface rgmii_rx_frame_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_err;
    logic [15:0] frame_len;

    modport master (output rx_data, rx_valid, rx_sop, rx_eop, rx_err, frame_len);
    modport slave  (input  rx_data, rx_valid, rx_sop, rx_eop, rx_err, frame_len);
endinterface

// File: rtl/rgmii_rx_frame_crc32_d8.sv
// One-byte step of the reflected (LSB-first) Ethernet CRC-32.
module crc32_d8
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Eight unrolled shift/xor steps, data bit 0 first.
    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rgmii_rx_frame.sv
// RGMII receive framer: control/in-band status decode, byte assembly for
// 1000 and 10/100 modes, preamble strip, length/FCS check and statistics.
module rgmii_rx_frame
    import eth_rx_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1522,
    parameter int MIN_FRAME_LEN = 64,
    parameter bit CHECK_FCS     = 1'b1,
    parameter int STAT_W        = 32
) (
    input  logic              gmii_rx_clk,
    input  logic              rst_n,
    input  logic [1:0]        cfg_speed,
    input  logic [3:0]        iddr_rxd_rise,
    input  logic [3:0]        iddr_rxd_fall,
    input  logic              iddr_ctl_rise,
    input  logic              iddr_ctl_fall,
    rgmii_rx_frame_if.master  rx,
    output logic              link_up,
    output logic [1:0]        link_speed,
    output logic              link_duplex,
    output logic [STAT_W-1:0] stat_good,
    output logic [STAT_W-1:0] stat_bad
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] OVF_LEN = 16'(MAX_FRAME_LEN + 1);

    rx_state_e         state_q, state_d;
    logic [1:0]        spd_q, spd_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              first_q, first_d;
    logic [3:0]        nib_q, nib_d;
    logic              phase_q, phase_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       crc_q, crc_d;
    logic              er_seen_q, er_seen_d;

    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              out_err_q, out_err_d;
    logic [15:0]       out_len_q, out_len_d;

    logic [3:0]        st_last_q, st_last_d;
    logic              st_seen_q, st_seen_d;
    logic              link_up_q, link_up_d;
    logic [1:0]        link_speed_q, link_speed_d;
    logic              link_duplex_q, link_duplex_d;

    logic [STAT_W-1:0] stat_good_q, stat_good_d;
    logic [STAT_W-1:0] stat_bad_q, stat_bad_d;

    logic              dv, er, gig;
    logic [7:0]        byte_gig;
    logic              asm_vld;
    logic [7:0]        asm_byte;
    logic [31:0]       crc_next;
    logic              frame_bad;

    assign dv       = iddr_ctl_rise;
    assign er       = iddr_ctl_rise ^ iddr_ctl_fall;
    // Speed is live in IDLE and frozen for the rest of the frame.
    assign gig      = (state_q == ST_IDLE) ? (cfg_speed == SPD_1000) : (spd_q == SPD_1000);
    assign byte_gig = {iddr_rxd_fall, iddr_rxd_rise};

    // A byte completes every dv cycle at 1000, every second nibble at 10/100.
    assign asm_vld  = (state_q == ST_PAYLOAD) && dv && (gig || phase_q);
    assign asm_byte = gig ? byte_gig : {iddr_rxd_rise, nib_q};

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (asm_byte),
        .crc_out (crc_next)
    );

    // Judged when dv drops; the CRC register already covers the held byte.
    assign frame_bad = er_seen_q
                     | (len_q < MIN_LEN)
                     | (CHECK_FCS && (bitrev32(crc_q) != CRC32_RESIDUE))
                     | (!gig && phase_q);

    // Next-state, datapath and status decode.
    always_comb begin
        logic sof, bump_good, bump_bad;
        state_d       = state_q;
        spd_d         = spd_q;
        hold_d        = hold_q;
        hold_vld_d    = hold_vld_q;
        first_d       = first_q;
        nib_d         = nib_q;
        phase_d       = phase_q;
        len_d         = len_q;
        crc_d         = crc_q;
        er_seen_d     = er_seen_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        out_sop_d     = 1'b0;
        out_eop_d     = 1'b0;
        out_err_d     = 1'b0;
        out_len_d     = out_len_q;
        st_last_d     = st_last_q;
        st_seen_d     = st_seen_q;
        link_up_d     = link_up_q;
        link_speed_d  = link_speed_q;
        link_duplex_d = link_duplex_q;
        stat_good_d   = stat_good_q;
        stat_bad_d    = stat_bad_q;
        sof           = 1'b0;
        bump_good     = 1'b0;
        bump_bad      = 1'b0;

        // In-band status must repeat on back-to-back idle cycles to be taken.
        if (!dv && !er) begin
            st_last_d = iddr_rxd_rise;
            st_seen_d = 1'b1;
            if (st_seen_q && (iddr_rxd_rise == st_last_q)) begin
                link_up_d     = iddr_rxd_rise[0];
                link_speed_d  = iddr_rxd_rise[2:1];
                link_duplex_d = iddr_rxd_rise[3];
            end
        end else begin
            st_seen_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                spd_d = cfg_speed;
                if (dv) begin
                    if (gig ? (byte_gig == PREAMBLE_BYTE) : (iddr_rxd_rise == PREAMBLE_NIB))
                        state_d = ST_PREAMBLE;
                    else
                        state_d = ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                end else if (gig) begin
                    if (byte_gig == SFD_BYTE)           sof = 1'b1;
                    else if (byte_gig != PREAMBLE_BYTE) state_d = ST_DROP;
                end else begin
                    if (iddr_rxd_rise == SFD_NIB)           sof = 1'b1;
                    else if (iddr_rxd_rise != PREAMBLE_NIB) state_d = ST_DROP;
                end
            end
            ST_PAYLOAD: begin
                if (dv) begin
                    // Only er alongside dv marks a corrupted byte.
                    if (er) er_seen_d = 1'b1;
                    if (!gig) begin
                        phase_d = ~phase_q;
                        if (!phase_q) nib_d = iddr_rxd_rise;
                    end
                    if (asm_vld) begin
                        crc_d      = crc_next;
                        hold_d     = asm_byte;
                        hold_vld_d = 1'b1;
                        len_d      = len_q + 16'd1;
                        if (hold_vld_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hold_q;
                            out_sop_d   = first_q;
                            first_d     = 1'b0;
                        end
                        // Oversize: close the frame on the held byte, discard the rest.
                        if (len_q == MAX_LEN) begin
                            out_eop_d  = 1'b1;
                            out_err_d  = 1'b1;
                            out_len_d  = OVF_LEN;
                            hold_vld_d = 1'b0;
                            bump_bad   = 1'b1;
                            state_d    = ST_DROP;
                        end
                    end
                end else begin
                    state_d    = ST_IDLE;
                    hold_vld_d = 1'b0;
                    if (hold_vld_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hold_q;
                        out_sop_d   = first_q;
                        out_eop_d   = 1'b1;
                        out_err_d   = frame_bad;
                        out_len_d   = len_q;
                        bump_good   = !frame_bad;
                        bump_bad    = frame_bad;
                    end else begin
                        // SFD with no complete byte behind it.
                        bump_bad = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (sof) begin
            state_d    = ST_PAYLOAD;
            hold_vld_d = 1'b0;
            first_d    = 1'b1;
            phase_d    = 1'b0;
            len_d      = 16'd0;
            crc_d      = CRC32_INIT;
            er_seen_d  = 1'b0;
        end

        if (bump_good && (stat_good_q != '1)) stat_good_d = stat_good_q + STAT_W'(1);
        if (bump_bad  && (stat_bad_q  != '1)) stat_bad_d  = stat_bad_q  + STAT_W'(1);
    end

    // FSM state register.
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath, output, status and statistics registers.
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            spd_q         <= 2'b00;
            hold_q        <= 8'h00;
            hold_vld_q    <= 1'b0;
            first_q       <= 1'b0;
            nib_q         <= 4'h0;
            phase_q       <= 1'b0;
            len_q         <= 16'd0;
            crc_q         <= CRC32_INIT;
            er_seen_q     <= 1'b0;
            out_data_q    <= 8'h00;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_err_q     <= 1'b0;
            out_len_q     <= 16'd0;
            st_last_q     <= 4'h0;
            st_seen_q     <= 1'b0;
            link_up_q     <= 1'b0;
            link_speed_q  <= 2'b00;
            link_duplex_q <= 1'b0;
            stat_good_q   <= '0;
            stat_bad_q    <= '0;
        end else begin
            spd_q         <= spd_d;
            hold_q        <= hold_d;
            hold_vld_q    <= hold_vld_d;
            first_q       <= first_d;
            nib_q         <= nib_d;
            phase_q       <= phase_d;
            len_q         <= len_d;
            crc_q         <= crc_d;
            er_seen_q     <= er_seen_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_err_q     <= out_err_d;
            out_len_q     <= out_len_d;
            st_last_q     <= st_last_d;
            st_seen_q     <= st_seen_d;
            link_up_q     <= link_up_d;
            link_speed_q  <= link_speed_d;
            link_duplex_q <= link_duplex_d;
            stat_good_q   <= stat_good_d;
            stat_bad_q    <= stat_bad_d;
        end
    end

    assign rx.rx_data   = out_data_q;
    assign rx.rx_valid  = out_valid_q;
    assign rx.rx_sop    = out_sop_q;
    assign rx.rx_eop    = out_eop_q;
    assign rx.rx_err    = out_err_q;
    assign rx.frame_len = out_len_q;

    assign link_up      = link_up_q;
    assign link_speed   = link_speed_q;
    assign link_duplex  = link_duplex_q;
    assign stat_good    = stat_good_q;
    assign stat_bad     = stat_bad_q;

endmodule

// File: doc/rgmii_rx_frame.md
Name: rgmii_rx_frame

Overview:
- Parametrised RGMII receive framer in the RX clock domain, downstream of the IDELAY/IDDR capture stage.
- Decodes RGMII control (DV/ER) and in-band link status, and reassembles bytes for 1000 and 10/100 modes.
- Strips preamble/SFD, checks length and FCS, and emits a byte stream with SOP/EOP/error plus saturating statistics.
- Feeds the UDP/PCIe packet path.

Parameters:
MAX_FRAME_LEN, 1522, largest accepted frame incl. FCS, in bytes
MIN_FRAME_LEN, 64, smallest accepted frame incl. FCS
CHECK_FCS, 1, 1 = CRC-32 residue check enabled; 0 = FCS never flags error
STAT_W, 32, width of statistics counters

Ports:
gmii_rx_clk  in  1  RX clock (125/25/2.5 MHz); the only clock
rst_n  in  1  asynchronous active-low reset
cfg_speed  in  2  2'b10=1000, 2'b01=100, 2'b00=10; sampled only in IDLE
iddr_rxd_rise  in  4  IDDR Q1 data (rising-edge nibble)
iddr_rxd_fall  in  4  IDDR Q2 data (falling-edge nibble)
iddr_ctl_rise  in  1  IDDR Q1 of rx_ctl
iddr_ctl_fall  in  1  IDDR Q2 of rx_ctl
rx_data  out  8  payload byte (dest MAC first, FCS included)
rx_valid  out  1  rx_data valid, one-cycle strobe per byte
rx_sop  out  1  first byte of frame, qualified by rx_valid
rx_eop  out  1  last byte of frame, qualified by rx_valid
rx_err  out  1  frame bad; meaningful only with rx_eop
frame_len  out  16  byte count incl. FCS; valid with rx_eop
link_up  out  1  in-band link status
link_speed  out  2  in-band speed, same encoding as cfg_speed
link_duplex  out  1  in-band duplex, 1 = full
stat_good  out  STAT_W  good frames, saturating
stat_bad  out  STAT_W  bad frames, saturating

Behaviour:
- Reset: every output and register is 0; FSM = IDLE; CRC = 0xFFFFFFFF.
- Control decode: dv = ctl_rise; er = ctl_rise ^ ctl_fall.
- In-band status:
  - Applies when dv=0 and er=0.
  - Field = rxd_rise: {duplex, speed[1:0], link} = bits {3, 2:1, 0}.
  - Outputs update only after the same value is seen on 2 consecutive such cycles.
- Byte assembly, 1000 mode: byte = {rxd_fall, rxd_rise}, one per dv cycle.
- Byte assembly, 10/100 modes:
  - One nibble per dv cycle (rxd_rise); byte = {second nibble, first nibble}.
  - Nibble phase is set by SFD detection.
- FSM states:
  - IDLE: a dv byte (1000 mode) or nibble (10/100) equal to 0x55 / 0x5 → PREAMBLE. Any other dv data → DROP.
  - PREAMBLE, 1000 mode: 0x55 stays; 0xD5 → PAYLOAD; anything else → DROP.
  - PREAMBLE, 10/100 modes: nibble 0x5 stays; 0xD after a 0x5 → PAYLOAD with phase cleared; anything else → DROP.
  - PREAMBLE: dv=0 → IDLE, with no output and no stat change.
  - PAYLOAD: see below.
  - DROP: ignore input until dv=0 → IDLE.
- PAYLOAD:
  - Each assembled byte enters a 1-byte hold register, increments the length counter and updates the CRC.
  - The held byte is emitted (rx_valid=1) on the cycle the next byte is assembled, so output lags input by one byte time. rx_sop=1 on the first emitted byte.
  - dv falling: the held byte is emitted next cycle with rx_eop=1; then → IDLE. A 1-byte frame has sop and eop in the same cycle.
  - rx_err at eop = any of: er seen during PAYLOAD; len < MIN_FRAME_LEN; CHECK_FCS and residue ≠ 0xC704DD7B; odd nibble count (10/100 only, trailing nibble discarded).
  - Length > MAX_FRAME_LEN: the held byte is emitted immediately with eop=1, err=1, frame_len=MAX_FRAME_LEN+1; then → DROP.
  - SFD followed by dv=0 with zero bytes: no output; stat_bad increments.
- Statistics: at each eop, stat_good or stat_bad increments by 1; both saturate at all-ones.
- cfg_speed change outside IDLE is ignored until the next IDLE.
- Async reset mid-frame: outputs drop to 0 immediately; no eop is issued for the truncated frame.

Decomposition:
- Shared package eth_rx_pkg holds:
  - speed encodings SPD_10/SPD_100/SPD_1000;
  - PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5;
  - CRC32_POLY 32'h04C11DB7, CRC32_RESIDUE 32'hC704DD7B;
  - FSM state typedef.
- One sub-module, crc32_d8: combinational 8-bit-parallel reflected CRC-32 next-state function.

Test Plan:
- 1000 mode, 7×0x55 + 0xD5 + 60 payload bytes + correct FCS → 64 rx_valid strobes; sop on byte 0, eop on byte 63; frame_len=64, rx_err=0, stat_good=1.
- 100 mode, same frame as nibbles low-first → identical byte stream and frame_len=64, rx_err=0. Repeat with one extra trailing nibble → rx_err=1, stat_bad=1.
- 1000 mode, 64-byte frame with er asserted (ctl_rise=1, ctl_fall=0) on byte 20 → frame delivered in full with eop rx_err=1.
- 1000 mode, 1523-byte frame, MAX_FRAME_LEN=1522 → eop after 1522 bytes with rx_err=1 and frame_len=1523; remaining input ignored; next good frame accepted normally.
- Idle with rxd_rise=4'hD for 1 cycle → no change; for 2 consecutive cycles → link_up=1, link_speed=2'b10, link_duplex=1.
- rst_n low at payload byte 30 → all outputs 0 at once; after release, a following good 64-byte frame → stat_good=1, stat_bad=0.
